// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: serial receive side of the host USB-RS232 link.
// Deserializes 8N1 frames from USB_RS232_RXD into bytes and queues them in a
// small first-word-fall-through FIFO for the command decoder.
// Optional macro UART_RX_PARITY_EN: frames become 8E1 (even parity bit before
// the stop bit) and ParityError becomes a live sticky flag.
module uart_cmd_receiver #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       USB_RS232_RXD,
    input  logic       ReadEnable,
    input  logic       ClearErrors,
    output logic [7:0] DataOut,
    output logic       DataAvailable,
    output logic       FramingError,
    output logic       ParityError,
    output logic       Overrun,
    output logic       Busy
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic          r_rx_meta;
    logic          r_rxs;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_busy;
    logic          r_frame_err;
    logic          r_overrun;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_bit_end;
    logic          w_push;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_write;

    assign w_bit_end = (r_cnt == LP_LAST);
    // A byte is pushed on the stop-sample edge only when the stop bit is high.
    assign w_push    = (r_state == S_STOP) && w_bit_end && r_rxs;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = ReadEnable && !w_empty;
    // When full, a simultaneous pop frees the slot being written this edge.
    assign w_write   = w_push && (!w_full || w_pop);

    // Two-flop synchronizer on the asynchronous line, preset to the idle level.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= USB_RS232_RXD;
            r_rxs     <= r_rx_meta;
        end
    end

    // Frame FSM: bit timing, state sequencing, Busy and the FramingError pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_cnt       <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == LP_HALF) begin
                        r_cnt <= '0;
                        if (!r_rxs) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (r_idx == 3'd7) r_state <= S_PARITY;
`else
                        if (r_idx == 3'd7) r_state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_BREAK;
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Data shift register, LSB first; a partial byte is simply overwritten later.
    always_ff @(posedge Clock) begin
        if (r_state == S_DATA && w_bit_end) r_shift[r_idx] <= r_rxs;
    end

    // FIFO storage is written without reset; empty pointers mask stale contents.
    always_ff @(posedge Clock) begin
        if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end

    // FIFO pointers with one extra wrap bit to tell full from empty.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky Overrun: a set event on the same edge as ClearErrors wins.
    always_ff @(posedge Clock) begin
        if (Reset)                              r_overrun <= 1'b0;
        else if (w_push && w_full && !w_pop)    r_overrun <= 1'b1;
        else if (ClearErrors)                   r_overrun <= 1'b0;
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;
    logic w_par_bad;

    // Even parity: the received parity bit must equal the XOR of the data bits.
    assign w_par_bad = (r_state == S_PARITY) && w_bit_end && (r_rxs != ^r_shift);

    // Sticky ParityError; the byte is still delivered.
    always_ff @(posedge Clock) begin
        if (Reset)            r_parity_err <= 1'b0;
        else if (w_par_bad)   r_parity_err <= 1'b1;
        else if (ClearErrors) r_parity_err <= 1'b0;
    end

    assign ParityError = r_parity_err;
`else
    assign ParityError = 1'b0;
`endif

    assign DataOut       = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign DataAvailable = !w_empty;
    assign FramingError  = r_frame_err;
    assign Overrun       = r_overrun;
    assign Busy          = r_busy;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Self-checking bench for uart_cmd_receiver (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Honours UART_RX_PARITY_EN when compiled with it.
module tb_uart_cmd_receiver;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Edges from driving the start bit to the stop-sample edge: two sync flops
    // plus the idle detect, half a bit to mid-start, then one bit per later bit.
    localparam int STOP_OFS = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       re  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] dout;
    logic       da, fe, pe, ovr, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    int da_rise = -1;
    logic da_prev = 1'b0;

    // Reference model: expected FIFO contents and sticky flags.
    logic [7:0] q[$];
    bit m_ovr = 1'b0;
    bit m_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit par_flip = 1'b0;
`endif

    uart_cmd_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(clk), .Reset(rst), .USB_RS232_RXD(rxd), .ReadEnable(re),
        .ClearErrors(clr), .DataOut(dout), .DataAvailable(da),
        .FramingError(fe), .ParityError(pe), .Overrun(ovr), .Busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        fe_cnt   <= fe_cnt + (fe ? 1 : 0);
        busy_cnt <= busy_cnt + (busy ? 1 : 0);
        da_prev  <= da;
        if (da && !da_prev) da_rise <= cyc;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drives one complete frame; the line is left at the stop-bit level.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        idle(CPB);
`endif
        rxd = stop_bit;
        idle(CPB);
    endtask

    // Sends a good frame and updates the model; optionally pops exactly on the stop-sample edge.
    task automatic send(input logic [7:0] b, input bit pop_at_stop, output int start);
        start = cyc;
        fork
            drive_frame(b, 1'b1);
            if (pop_at_stop) begin
                idle(STOP_OFS - 1);
                n_cmp++;
                if (dout !== q[0]) begin
                    n_err++;
                    $display("FAIL pop_at_stop_head: got %h want %h", dout, q[0]);
                end
                re = 1'b1;
                idle(1);
                re = 1'b0;
                void'(q.pop_front());
            end
        join
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (par_flip) m_perr = 1'b1;
`endif
    endtask

    // Pops one entry, checking head and DataAvailable against the model.
    task automatic pop_one();
        n_cmp++;
        if (da !== (q.size() != 0)) begin
            n_err++;
            $display("FAIL pop_da: got %b want %b", da, q.size() != 0);
        end
        if (q.size() != 0) begin
            n_cmp++;
            if (dout !== q[0]) begin
                n_err++;
                $display("FAIL pop_dout: got %h want %h", dout, q[0]);
            end
        end
        re = 1'b1;
        idle(1);
        re = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (da !== 1'b0)    begin n_err++; $display("FAIL reset_da: got %b want 0", da); end
        n_cmp++; if (fe !== 1'b0)    begin n_err++; $display("FAIL reset_fe: got %b want 0", fe); end
        n_cmp++; if (pe !== 1'b0)    begin n_err++; $display("FAIL reset_pe: got %b want 0", pe); end
        n_cmp++; if (ovr !== 1'b0)   begin n_err++; $display("FAIL reset_ovr: got %b want 0", ovr); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int n;
        int f0;
        f0 = fe_cnt;
        send(8'hA5, 1'b0, n);
        n_cmp++; if (da_rise !== n + STOP_OFS) begin n_err++; $display("FAIL basic_latency: got cycle %0d want %0d", da_rise, n + STOP_OFS); end
        n_cmp++; if (da !== 1'b1)     begin n_err++; $display("FAIL basic_da: got %b want 1", da); end
        n_cmp++; if (dout !== 8'hA5)  begin n_err++; $display("FAIL basic_dout: got %h want a5", dout); end
        pop_one();
        n_cmp++; if (da !== 1'b0)     begin n_err++; $display("FAIL basic_da_after_pop: got %b want 0", da); end
        n_cmp++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL basic_fe: got %0d pulses want 0", fe_cnt - f0); end
        n_cmp++; if (ovr !== 1'b0 || pe !== m_perr) begin n_err++; $display("FAIL basic_flags: got ovr=%b pe=%b want 0 %b", ovr, pe, m_perr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        int n;
        bytes = '{8'h32, 8'hAA, 8'hCC, 8'hF0, 8'h55};
        for (int i = 0; i < 5; i++) send(bytes[i], 1'b0, n);
        idle(4);
        n_cmp++; if (ovr !== m_ovr) begin n_err++; $display("FAIL b2b_overrun: got %b want %b", ovr, m_ovr); end
        for (int i = 0; i < 4; i++) pop_one();
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL b2b_extra_byte: got da=%b want 0", da); end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        m_ovr = 1'b0;
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL b2b_clear: got %b want 0", ovr); end
    endtask

    task automatic test_glitch();
        int b0;
        int f0;
        b0 = busy_cnt;
        f0 = fe_cnt;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(20);
        n_cmp++; if (busy_cnt - b0 < 1 || busy_cnt - b0 > 10) begin n_err++; $display("FAIL glitch_busy_len: got %0d cycles want 1..10", busy_cnt - b0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
        n_cmp++; if (da !== 1'b0)   begin n_err++; $display("FAIL glitch_push: got da=%b want 0", da); end
        n_cmp++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_framing();
        int f0;
        int n;
        f0 = fe_cnt;
        drive_frame(8'h3C, 1'b0);
        idle(3 * CPB);
        rxd = 1'b1;
        idle(10);
        n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL framing_pulses: got %0d want 1", fe_cnt - f0); end
        n_cmp++; if (da !== 1'b0)   begin n_err++; $display("FAIL framing_push: got da=%b want 0", da); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL framing_busy: got %b want 0", busy); end
        send(8'h81, 1'b0, n);
        pop_one();
        n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL framing_after: got %0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int n;
        int b0;
        send(8'($urandom), 1'b0, n);
        b = 8'($urandom);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = b[4];
        idle(CPB / 2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %b want 1", busy); end
        rst = 1'b1;
        rxd = 1'b1;
        idle(2);
        rst = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_perr = 1'b0;
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL midreset_dout: got %h want 00", dout); end
        n_cmp++; if (da !== 1'b0)    begin n_err++; $display("FAIL midreset_da: got %b want 0", da); end
        n_cmp++; if (busy !== 1'b0 || fe !== 1'b0 || pe !== 1'b0 || ovr !== 1'b0) begin
            n_err++; $display("FAIL midreset_flags: got busy=%b fe=%b pe=%b ovr=%b want 0000", busy, fe, pe, ovr);
        end
        b0 = busy_cnt;
        idle(12 * CPB);
        n_cmp++; if (busy_cnt - b0 !== 0 || da !== 1'b0) begin n_err++; $display("FAIL midreset_idle: got busy_cycles=%0d da=%b want 0 0", busy_cnt - b0, da); end
    endtask

    task automatic test_push_pop_full();
        int n;
        for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b0, n);
        send(8'($urandom), 1'b1, n);
        idle(2);
        n_cmp++; if (ovr !== m_ovr) begin n_err++; $display("FAIL pushpop_overrun: got %b want %b", ovr, m_ovr); end
        for (int i = 0; i < DEPTH; i++) pop_one();
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL pushpop_drain: got da=%b want 0", da); end
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), 1'b0, n);
            repeat ($urandom_range(0, 2)) pop_one();
            idle($urandom_range(0, 5));
            n_cmp++; if (ovr !== m_ovr || pe !== m_perr) begin n_err++; $display("FAIL random_flags: got ovr=%b pe=%b want %b %b", ovr, pe, m_ovr, m_perr); end
            if (m_ovr && $urandom_range(0, 1) == 1) begin
                clr = 1'b1;
                idle(1);
                clr = 1'b0;
                m_ovr = 1'b0;
                m_perr = 1'b0;
            end
        end
        while (q.size() != 0) pop_one();
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL random_drain: got da=%b want 0", da); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n;
        par_flip = 1'b0;
        send(8'h07, 1'b0, n);
        pop_one();
        n_cmp++; if (pe !== m_perr) begin n_err++; $display("FAIL parity_good: got %b want %b", pe, m_perr); end
        par_flip = 1'b1;
        send(8'h07, 1'b0, n);
        par_flip = 1'b0;
        pop_one();
        idle(20);
        n_cmp++; if (pe !== m_perr) begin n_err++; $display("FAIL parity_bad_sticky: got %b want %b", pe, m_perr); end
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        m_perr = 1'b0;
        n_cmp++; if (pe !== 1'b0) begin n_err++; $display("FAIL parity_clear: got %b want 0", pe); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_push_pop_full();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_receiver.md
Name: uart_cmd_receiver

Overview:
- Receive side of the host USB-RS232 serial link: deserializes 8N1 (optionally 8E1) frames arriving on USB_RS232_RXD into bytes.
- Buffers received bytes in a small first-word-fall-through (FWFT) FIFO for the command decoder.
- Mirror of the existing transmit wrapper: same clock domain, same bit timing, opposite direction.

Parameters:
- CLKS_PER_BIT, 100, system clocks per serial bit (100 MHz / 1 Mbaud); must be ≥ 8.
- FIFO_DEPTH, 4, entries in the receive byte FIFO; power of two, 2..16.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- USB_RS232_RXD  in  1  asynchronous serial input; idles high.
- ReadEnable  in  1  pop FIFO head; ignored when DataAvailable=0.
- ClearErrors  in  1  clears the sticky Overrun and ParityError flags.
- DataOut  out  8  FIFO head byte; valid while DataAvailable=1.
- DataAvailable  out  1  FIFO not empty.
- FramingError  out  1  one-cycle pulse on a bad stop bit.
- ParityError  out  1  sticky; stays 0 unless UART_RX_PARITY_EN is defined.
- Overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- Busy  out  1  FSM not in IDLE.

Behaviour:
- Reset, all outputs: DataOut=0, DataAvailable=0, FramingError=0, ParityError=0, Overrun=0, Busy=0. FIFO emptied; FSM to IDLE; synchronizer flops preset to 1.
- Reset mid-frame: the partial byte is discarded; the FSM waits in IDLE for the next falling edge.
- Input synchronization: 2-flop synchronizer on RxD; all decisions use the second flop (rxs).
- Bit counter: cnt counts 0..CLKS_PER_BIT-1; reloads to 0 on each state entry.
- IDLE: rxs=0 → START, cnt=0.
- START: at cnt=CLKS_PER_BIT/2-1, sample rxs (mid-bit).
  - 0 → DATA, bit index 0.
  - 1 → IDLE (glitch rejected, no error).
- DATA: every CLKS_PER_BIT clocks, sample rxs into shift[idx], LSB first.
  - After idx 7 → PARITY if enabled, else STOP.
- PARITY (macro only): one bit-time later, sample.
  - Mismatch against even parity of the 8 data bits sets ParityError.
  - The byte is still delivered.
- STOP: one bit-time later, sample.
  - rxs=1 → push the byte into the FIFO on that edge; go to IDLE.
  - rxs=0 → FramingError pulses high for 1 cycle; byte discarded; go to BREAK.
- BREAK: hold until rxs=1, then IDLE. Line held low produces exactly one FramingError.
- Push latency: DataAvailable and DataOut are valid the cycle after the stop-sample edge. The stop-sample edge falls 0.5 bit-time before the nominal frame end.
- FIFO, FWFT: DataOut always shows the head entry.
  - ReadEnable with DataAvailable=1 pops; the next entry (or DataAvailable=0) appears the following cycle.
  - Push when full → byte dropped; Overrun set.
  - Simultaneous push and pop when full → both occur; no Overrun.
  - Pop when empty → ignored.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- Flag clearing: ClearErrors clears Overrun/ParityError on the next edge. If a set event coincides with ClearErrors, set wins.
- Busy: 1 in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is start + 8 data + even parity + stop; the PARITY state exists and ParityError is live.
- Undefined: 8N1 frame; no PARITY state; ParityError tied to 0.

Test Plan:
- Basic receive: CLKS_PER_BIT=16; send 0xA5 (8N1) → DataAvailable rises 1 cycle after the stop sample; DataOut=0xA5; ReadEnable for 1 cycle → DataAvailable=0; no error flags.
- Back-to-back, no reads: send 0x32, 0xAA, 0xCC, 0xF0, 0x55 with FIFO_DEPTH=4 and no ReadEnable → first four bytes read back in order 0x32, 0xAA, 0xCC, 0xF0; Overrun=1; 0x55 absent; ClearErrors → Overrun=0.
- Glitch rejection: 5-clock low pulse on RxD → returns to IDLE; no push; Busy high ≤ 10 cycles.
- Framing error: send 0x3C with stop bit 0, then hold RxD low 3 bit-times → exactly one FramingError pulse; no push; next valid frame 0x81 is received correctly.
- Reset and simultaneous push/pop: assert Reset at data bit 4 → all outputs 0. Then fill the FIFO, and on the stop-sample edge of a 5th byte assert ReadEnable → no Overrun; that byte becomes the last entry.
- Parity (macro defined): send 0x07 with parity bit 1 → byte delivered, ParityError stays 0. Send 0x07 with parity bit 0 → byte delivered, ParityError=1 (sticky).
